// File: rtl/fwd_hazard_unit.sv
// Operand bypass selection, load-use detection and a one-deep mul/div countdown scoreboard.
// Optional WB buffer (forward code 11) is enabled by defining FWD_WB_BUF_EN.
//
// scoreboard state | meaning
// IDLE (cnt == 0)  | no mul/div outstanding, md_start accepted unless stalled
// BUSY (cnt != 0)  | result pending; cnt == 1 is the md_done cycle
module fwd_hazard_unit #(
    parameter int ADDR_W = 5,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_md_op,
    input  logic [ADDR_W-1:0] id_ex_rs,
    input  logic [ADDR_W-1:0] id_ex_rt,
    input  logic              id_ex_mem_read,
    input  logic [ADDR_W-1:0] id_ex_reg_write_addr,
    input  logic              ex_mem_reg_write,
    input  logic [ADDR_W-1:0] ex_mem_reg_write_addr,
    input  logic              mem_wb_reg_write,
    input  logic [ADDR_W-1:0] mem_wb_reg_write_addr,
    input  logic              md_start,
    input  logic [ADDR_W-1:0] md_dst,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic              flush_id_ex,
    output logic              md_busy,
    output logic              md_done
);

    localparam logic [3:0] MD_LAT_C = 4'(MD_LAT);

    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] md_dst_q, md_dst_d;
    logic              ex_mem_live, mem_wb_live, wb_live;
    logic [ADDR_W-1:0] wb_addr;
    logic              load_use, md_raw, md_hazard;

    assign ex_mem_live = ex_mem_reg_write && (ex_mem_reg_write_addr != '0);
    assign mem_wb_live = mem_wb_reg_write && (mem_wb_reg_write_addr != '0);

`ifdef FWD_WB_BUF_EN
    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;

    always_comb begin
        wb_valid_d = mem_wb_live;
        wb_addr_d  = mem_wb_reg_write_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
        end
    end

    assign wb_live = wb_valid_q;
    assign wb_addr = wb_addr_q;
`else
    assign wb_live = 1'b0;
    assign wb_addr = '0;
`endif

    // Bypass priority: EX/MEM, MEM/WB, WB buffer, register file.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (ex_mem_live && ex_mem_reg_write_addr == id_ex_rs)      forward_a = 2'b10;
        else if (mem_wb_live && mem_wb_reg_write_addr == id_ex_rs) forward_a = 2'b01;
        else if (wb_live && wb_addr == id_ex_rs)                   forward_a = 2'b11;
        if (ex_mem_live && ex_mem_reg_write_addr == id_ex_rt)      forward_b = 2'b10;
        else if (mem_wb_live && mem_wb_reg_write_addr == id_ex_rt) forward_b = 2'b01;
        else if (wb_live && wb_addr == id_ex_rt)                   forward_b = 2'b11;
    end

    always_comb begin
        load_use = id_ex_mem_read && (id_ex_reg_write_addr != '0) &&
                   ((id_ex_reg_write_addr == id_rs) ||
                    (id_uses_rt && id_ex_reg_write_addr == id_rt));
        md_raw   = (md_dst_q != '0) &&
                   ((md_dst_q == id_rs) || (id_uses_rt && md_dst_q == id_rt));
        // The dependent instruction issues in the md_done cycle itself.
        md_hazard = md_busy && !md_done && (md_raw || id_md_op);
    end

    assign md_busy     = (cnt_q != 4'd0);
    assign md_done     = (cnt_q == 4'd1);
    assign stall       = load_use || md_hazard;
    assign flush_id_ex = stall;

    // md_start during BUSY (including the md_done cycle) is dropped.
    always_comb begin
        cnt_d    = cnt_q;
        md_dst_d = md_dst_q;
        if (cnt_q == 4'd0) begin
            if (md_start && !stall) begin
                cnt_d    = MD_LAT_C;
                md_dst_d = md_dst;
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 4'd0;
            md_dst_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            md_dst_q <= md_dst_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (ADDR_W = 5, MD_LAT = 4); expectations follow FWD_WB_BUF_EN.
module tb_fwd_hazard_unit;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_rs, id_rt, id_ex_rs, id_ex_rt, id_ex_reg_write_addr;
    logic [AW-1:0] ex_mem_reg_write_addr, mem_wb_reg_write_addr, md_dst;
    logic          id_uses_rt, id_md_op, id_ex_mem_read, ex_mem_reg_write;
    logic          mem_wb_reg_write, md_start;
    logic [1:0]    forward_a, forward_b;
    logic          stall, flush_id_ex, md_busy, md_done;

    int n_cmp = 0;
    int n_bad = 0;

    fwd_hazard_unit #(.ADDR_W(AW), .MD_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_md_op(id_md_op),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_reg_write_addr(id_ex_reg_write_addr),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_reg_write_addr(ex_mem_reg_write_addr),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_reg_write_addr(mem_wb_reg_write_addr),
        .md_start(md_start), .md_dst(md_dst),
        .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
        .flush_id_ex(flush_id_ex), .md_busy(md_busy), .md_done(md_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_md_op = 1'b0;
        id_ex_rs = '0; id_ex_rt = '0; id_ex_mem_read = 1'b0; id_ex_reg_write_addr = '0;
        ex_mem_reg_write = 1'b0; ex_mem_reg_write_addr = '0;
        mem_wb_reg_write = 1'b0; mem_wb_reg_write_addr = '0;
        md_start = 1'b0; md_dst = '0;
    endtask

    initial begin
        logic [1:0] exp_wb;
`ifdef FWD_WB_BUF_EN
        exp_wb = 2'b11;
`else
        exp_wb = 2'b00;
`endif
        clear_inputs();
        rst = 1'b1;

        // reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_busy", {1'b0, md_busy}, 2'b00);
        chk("rst_done", {1'b0, md_done}, 2'b00);
        chk("rst_stall", {1'b0, stall}, 2'b00);
        chk("rst_fwd_a", forward_a, 2'b00);
        chk("rst_fwd_b", forward_b, 2'b00);
        id_ex_mem_read = 1'b1; id_ex_reg_write_addr = 5'd3; id_rs = 5'd3; #1;
        chk("rst_loaduse_stall", {1'b0, stall}, 2'b01);
        clear_inputs();
        @(negedge clk); rst = 1'b0;

        // forwarding priority
        @(negedge clk);
        ex_mem_reg_write = 1'b1; ex_mem_reg_write_addr = 5'd8;
        mem_wb_reg_write = 1'b1; mem_wb_reg_write_addr = 5'd8;
        id_ex_rs = 5'd8; id_ex_rt = 5'd9; #1;
        chk("prio_exmem_a", forward_a, 2'b10);
        chk("prio_none_b", forward_b, 2'b00);
        ex_mem_reg_write_addr = 5'd9; #1;
        chk("prio_memwb_a", forward_a, 2'b01);
        chk("prio_exmem_b", forward_b, 2'b10);
        ex_mem_reg_write = 1'b0; #1;
        chk("exmem_we_low_b", forward_b, 2'b00);

        // register zero
        @(negedge clk); clear_inputs();
        ex_mem_reg_write = 1'b1; mem_wb_reg_write = 1'b1; #1;
        chk("r0_a", forward_a, 2'b00);
        chk("r0_b", forward_b, 2'b00);
        @(negedge clk); #1;
        chk("r0_a_after_edge", forward_a, 2'b00);
        chk("r0_b_after_edge", forward_b, 2'b00);

        // WB buffer
        @(negedge clk); clear_inputs();
        mem_wb_reg_write = 1'b1; mem_wb_reg_write_addr = 5'd5;
        @(negedge clk); #1;
        id_ex_rt = 5'd5; #1;
        chk("memwb_over_buf_b", forward_b, 2'b01);
        @(negedge clk);
        mem_wb_reg_write = 1'b0; mem_wb_reg_write_addr = '0; #1;
        chk("wb_buf_b", forward_b, exp_wb);
        id_ex_rs = 5'd5; #1;
        chk("wb_buf_a", forward_a, exp_wb);
        @(negedge clk); #1;
        chk("wb_buf_expired_b", forward_b, 2'b00);

        // load-use
        @(negedge clk); clear_inputs();
        id_ex_mem_read = 1'b1; id_ex_reg_write_addr = 5'd3; id_rs = 5'd3; #1;
        chk("loaduse_stall", {1'b0, stall}, 2'b01);
        chk("loaduse_flush", {1'b0, flush_id_ex}, 2'b01);
        @(negedge clk);
        id_ex_mem_read = 1'b0; id_ex_reg_write_addr = 5'd0; id_ex_rs = 5'd3;
        ex_mem_reg_write = 1'b1; ex_mem_reg_write_addr = 5'd3; #1;
        chk("loaduse_next_stall", {1'b0, stall}, 2'b00);
        chk("loaduse_next_fwd", forward_a, 2'b10);
        @(negedge clk); clear_inputs();
        id_ex_mem_read = 1'b1; id_ex_reg_write_addr = 5'd3; id_rs = 5'd4; id_rt = 5'd3; #1;
        chk("loaduse_rt_unused", {1'b0, stall}, 2'b00);
        id_uses_rt = 1'b1; #1;
        chk("loaduse_rt_used", {stall, flush_id_ex}, 2'b11);
        id_ex_reg_write_addr = 5'd0; id_rt = 5'd0; #1;
        chk("loaduse_r0", {1'b0, stall}, 2'b00);

        // scoreboard RAW
        @(negedge clk); clear_inputs();
        md_start = 1'b1; md_dst = 5'd7; id_rs = 5'd7; #1;
        chk("md_pre_busy", {md_busy, stall}, 2'b00);
        @(negedge clk);
        md_start = 1'b1; md_dst = 5'd2; #1;   // ignored while busy
        chk("md_c1", {md_busy, stall}, 2'b11);
        chk("md_c1_done", {1'b0, md_done}, 2'b00);
        @(negedge clk); md_start = 1'b0; #1;
        chk("md_c2", {md_busy, stall}, 2'b11);
        @(negedge clk); #1;
        chk("md_c3", {md_busy, stall}, 2'b11);
        chk("md_c3_done", {1'b0, md_done}, 2'b00);
        @(negedge clk);
        md_start = 1'b1; md_dst = 5'd7; #1;   // ignored in done cycle
        chk("md_c4", {md_busy, stall}, 2'b10);
        chk("md_c4_done", {1'b0, md_done}, 2'b01);
        @(negedge clk); md_start = 1'b0; #1;
        chk("md_after", {md_busy, md_done}, 2'b00);
        chk("md_after_stall", {1'b0, stall}, 2'b00);

        // structural hazard, then reset in 2nd busy cycle
        @(negedge clk); clear_inputs();
        md_start = 1'b1; md_dst = 5'd7;
        @(negedge clk); md_start = 1'b0; id_md_op = 1'b1; #1;
        chk("md_struct", {md_busy, stall}, 2'b11);
        id_md_op = 1'b0; id_rs = 5'd6; #1;
        chk("md_nodep", {md_busy, stall}, 2'b10);
        id_rs = 5'd7;
        @(negedge clk); #1;
        chk("md_busy2", {md_busy, stall}, 2'b11);
        rst = 1'b1; #1;
        chk("md_rst_drop", {md_busy, stall}, 2'b00);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("md_rst_no_done", {md_busy, md_done}, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard-control block for the five-stage pipeline. It selects operand bypass sources for the EX stage and detects load-use hazards. It also tracks one outstanding multi-cycle multiply/divide result in a countdown scoreboard, and raises a single stall/bubble request to the PC, IF/ID and ID/EX registers. It sits beside the decode stage and sees addresses only, never data.

## Interface
Parameters:
- ADDR_W, 5, register-address width
- MD_LAT, 4, multiply/divide latency in cycles, legal range 2..15

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-high reset
- id_rs  input  ADDR_W  rs of the instruction in decode
- id_rt  input  ADDR_W  rt of the instruction in decode
- id_uses_rt  input  1  decode instruction reads rt
- id_md_op  input  1  decode instruction is a mul/div
- id_ex_rs  input  ADDR_W  rs of the instruction in EX
- id_ex_rt  input  ADDR_W  rt of the instruction in EX
- id_ex_mem_read  input  1  instruction in EX is a load
- id_ex_reg_write_addr  input  ADDR_W  destination of the instruction in EX
- ex_mem_reg_write  input  1  EX/MEM writes the register file
- ex_mem_reg_write_addr  input  ADDR_W  EX/MEM destination
- mem_wb_reg_write  input  1  MEM/WB writes the register file
- mem_wb_reg_write_addr  input  ADDR_W  MEM/WB destination
- md_start  input  1  mul/div issued from EX this cycle
- md_dst  input  ADDR_W  destination of the issued mul/div
- forward_a  output  2  EX operand A source: 00 register file, 01 MEM/WB, 10 EX/MEM, 11 WB buffer
- forward_b  output  2  EX operand B source, same encoding as forward_a
- stall  output  1  hold PC and IF/ID
- flush_id_ex  output  1  insert a bubble into ID/EX
- md_busy  output  1  a mul/div result is outstanding
- md_done  output  1  mul/div result is available this cycle

## Operation
- Forwarding is combinational and evaluated per operand (A against id_ex_rs, B against id_ex_rt).
- Priority order is EX/MEM (10), then MEM/WB (01), then WB buffer (11), then 00.
- A source matches only when its write-enable is high, its address is nonzero and its address equals the operand address. Register 0 is never forwarded.
- WB buffer is a register of {valid, addr}. Each cycle it loads valid = mem_wb_reg_write && (mem_wb_reg_write_addr != 0) and addr = mem_wb_reg_write_addr. It covers register files without write-through.
- Load-use hazard:
  - Condition: id_ex_mem_read && id_ex_reg_write_addr != 0 && (id_ex_reg_write_addr == id_rs || (id_uses_rt && id_ex_reg_write_addr == id_rt)).
  - Response: stall for one cycle.
- Scoreboard state is a counter cnt (4 bits) and a register md_dst_q.
  - IDLE (cnt == 0): when md_start is high and stall is low, load cnt = MD_LAT and md_dst_q = md_dst.
  - BUSY (cnt != 0): decrement cnt by 1 each cycle.
  - md_done = (cnt == 1).
  - md_busy = (cnt != 0).
  - md_start while BUSY is a protocol violation. It is ignored and leaves cnt unchanged.
- Mul/div hazard is raised while md_busy, under either of two conditions:
  - RAW: md_dst_q != 0 and md_dst_q matches id_rs, or matches id_rt when id_uses_rt.
  - Structural: id_md_op is high.
- The dependent instruction stalls until md_done is high, and issues in that cycle.
- Stall outputs: stall = load_use || md_hazard, gated by md_done for the md_hazard term. flush_id_ex = stall.
- When both hazards are present, the result is the OR of the two. A single stall covers both.

## Timing
- Forward outputs, stall and flush_id_ex are zero-latency combinational.
- Reset values:
  - cnt = 0 and WB buffer valid = 0.
  - Consequently md_busy = 0 and md_done = 0.
  - stall and flush_id_ex are low unless a load-use condition is present on the inputs.
  - forward_a/forward_b are 00 given deasserted write-enables.
- Reset mid-operation clears cnt asynchronously, so md_busy drops in the same cycle. No md_done is produced for the aborted operation.
- Load-use stall lasts exactly one cycle. In the next cycle the load is in MEM and forwarding code 10 or 01 resolves it.
- Scoreboard:
  - md_busy is high for MD_LAT cycles after the md_start edge.
  - md_done is high in the last of those cycles.
- md_start in the same cycle as md_done is ignored (still BUSY). The mul/div unit must issue it again.

## Configuration
- FWD_WB_BUF_EN defined: the WB buffer register exists and code 11 can be produced.
- FWD_WB_BUF_EN undefined: there is no buffer register, code 11 is never output, and the priority order ends at MEM/WB.

## Test plan
- Forwarding priority: EX/MEM and MEM/WB both write r8, id_ex_rs = 8 -> forward_a = 10. Change ex_mem_reg_write_addr to 9 -> forward_a = 01.
- Register zero: all write-enables high with address 0, id_ex_rs = id_ex_rt = 0 -> forward_a = forward_b = 00.
- WB buffer, with FWD_WB_BUF_EN defined:
  - Cycle N: MEM/WB writes r5. Cycle N+1: no writers, id_ex_rt = 5 -> forward_b = 11.
  - Same stimulus with the macro undefined -> forward_b = 00.
- Load-use: load to r3 in EX, decode rs = 3 -> stall = flush_id_ex = 1 for exactly one cycle. Same stimulus with id_uses_rt = 0 and id_rt = 3 -> stall = 0.
- Scoreboard with MD_LAT = 4: md_start with md_dst = 7, decode reads r7.
  - Expect md_busy high for 4 cycles, stall high for the first 3 of them, and md_done high together with stall = 0 in the 4th.
  - A second md_start during BUSY -> ignored.
- Reset in the 2nd BUSY cycle -> md_busy and stall drop immediately, and no md_done follows.
